// File: rtl/present_pkg.sv
// Shared PRESENT-80 primitives: S-boxes, bit permutations and key-schedule steps
// used by both the encryption and decryption cores.
package present_pkg;

  localparam int KEY_W = 80;
  localparam int BLK_W = 64;
  localparam int RC_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYEXP,
    S_DEC,
    S_FIN
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < BLK_W / 4; i++) r[4*i +: 4] = SBOX[s[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < BLK_W / 4; i++) r[4*i +: 4] = INV_SBOX[s[4*i +: 4]];
    return r;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays in place.
  function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < BLK_W - 1; i++) r[(16 * i) % 63] = s[i];
    r[BLK_W-1] = s[BLK_W-1];
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] inv_p_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < BLK_W - 1; i++) r[i] = s[(16 * i) % 63];
    r[BLK_W-1] = s[BLK_W-1];
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_update_fwd(input logic [KEY_W-1:0] k,
                                                      input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = SBOX[t[79:76]];
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  // Exact inverse of key_update_fwd: undo the counter XOR, the S-box, then rotate back.
  function automatic logic [KEY_W-1:0] key_update_inv(input logic [KEY_W-1:0] k,
                                                      input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ rc;
    t[79:76]   = INV_SBOX[t[79:76]];
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/present_inv_round.sv
// One combinational PRESENT inverse round: add round key, inverse permutation, inverse S-box.
module present_inv_round
  import present_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] rkey,
  output logic [BLK_W-1:0] nxt
);

  assign nxt = inv_sbox_layer(inv_p_layer(state ^ rkey));

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption: expands the key forward to K32, then runs the
// rounds backwards one per clock, optionally caching K32 for the last master key.
module present_decrypt
  import present_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1,
  parameter int ROUNDS    = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] mkey,
  input  logic [BLK_W-1:0] ciphertext,
  output logic [BLK_W-1:0] plaintext,
  output logic             busy,
  output logic             done,
  output logic             cache_hit
);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS);

  state_e           fsm, fsm_nxt;
  logic [BLK_W-1:0] blk, blk_nxt;
  logic [KEY_W-1:0] key, key_fwd_nxt, key_inv_nxt;
  logic [RC_W-1:0]  rc;
  logic             cache_valid;
  logic [KEY_W-1:0] mkey_lat, mkey_cache, k32_cache;
  logic             hit;

  assign hit         = KEY_CACHE && cache_valid && (mkey == mkey_cache);
  assign key_fwd_nxt = key_update_fwd(key, rc);
  assign key_inv_nxt = key_update_inv(key, rc);

  present_inv_round u_inv_round (
    .state (blk),
    .rkey  (key[KEY_W-1 -: BLK_W]),
    .nxt   (blk_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= S_IDLE;
    else      fsm <= fsm_nxt;
  end

  // NOTE: fsm_nxt is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      S_IDLE:   if (start) fsm_nxt = hit ? S_DEC : S_KEYEXP;
      S_KEYEXP: if (rc == RC_LAST) fsm_nxt = S_DEC;
      S_DEC:    if (rc == RC_W'(1)) fsm_nxt = S_FIN;
      S_FIN:    fsm_nxt = S_IDLE;
      default:  fsm_nxt = S_IDLE;
    endcase
  end

  // NOTE: the K32 cache is a plain register set, so it is cleared on reset along
  // with everything else; cache_valid alone would suffice but this keeps state clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk         <= '0;
      key         <= '0;
      rc          <= '0;
      plaintext   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cache_hit   <= 1'b0;
      cache_valid <= 1'b0;
      mkey_lat    <= '0;
      mkey_cache  <= '0;
      k32_cache   <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            blk      <= ciphertext;
            busy     <= 1'b1;
            mkey_lat <= mkey;
            if (hit) begin
              key       <= k32_cache;
              rc        <= RC_LAST;
              cache_hit <= 1'b1;
            end else begin
              key       <= mkey;
              rc        <= RC_W'(1);
              cache_hit <= 1'b0;
            end
          end
        end
        S_KEYEXP: begin
          key <= key_fwd_nxt;
          if (rc == RC_LAST) begin
            if (KEY_CACHE) begin
              k32_cache   <= key_fwd_nxt;
              mkey_cache  <= mkey_lat;
              cache_valid <= 1'b1;
            end
          end else begin
            rc <= rc + RC_W'(1);
          end
        end
        S_DEC: begin
          blk <= blk_nxt;
          key <= key_inv_nxt;
          // rc parks at 1 after the last inverse round rather than reaching 0
          if (rc != RC_W'(1)) rc <= rc - RC_W'(1);
        end
        S_FIN: begin
          plaintext <= blk ^ key[KEY_W-1 -: BLK_W];
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_decrypt.sv
// Scoreboard bench for present_decrypt: a behavioural PRESENT-80 encryptor creates
// ciphertexts, an issuer queues expected results, and a monitor checks every done.
module tb_present_decrypt;

  localparam int ROUNDS    = 31;
  localparam bit KEY_CACHE = 1'b1;
  localparam int LAT_MISS  = 2 * ROUNDS + 1;
  localparam int LAT_HIT   = ROUNDS + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [79:0] mkey = '0;
  logic [63:0] ciphertext = '0;
  logic [63:0] plaintext;
  logic        busy, done, cache_hit;

  present_decrypt #(.KEY_CACHE(KEY_CACHE), .ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mkey       (mkey),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .cache_hit  (cache_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pt;
    bit          hit;
    int unsigned start_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int unsigned last_done_cyc = 0;
  int unsigned prev_done_cyc = 0;
  logic [63:0] exp_pt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference PRESENT-80 encryption straight from the cipher definition.
  function automatic logic [63:0] present_enc(input logic [79:0] k, input logic [63:0] p);
    int          sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [63:0] s, t;
    logic [79:0] kr;
    s  = p;
    kr = k;
    for (int r = 1; r <= ROUNDS; r++) begin
      s = s ^ kr[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s  = t;
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = 4'(sb[kr[79:76]]);
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    return s ^ kr[79:16];
  endfunction

  // Issuer: a start seen while idle is accepted on the next edge; queue its expectation.
  bit          m_valid = 1'b0;
  logic [79:0] m_key = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      m_valid = 1'b0;
    end else if (start && !busy) begin
      e.hit       = KEY_CACHE && m_valid && (mkey == m_key);
      e.pt        = exp_pt;
      e.start_cyc = cyc + 1;
      if (!e.hit) begin
        m_valid = 1'b1;
        m_key   = mkey;
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: checks busy across each operation and every done against the queue head.
  bit busy_err = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb_q.delete();
      busy_err = 1'b0;
    end else begin
      if (sb_q.size() != 0 && cyc >= sb_q[0].start_cyc && !done && !busy) busy_err = 1'b1;
      if (done) begin
        n_done++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        check("done_expected", 80'(sb_q.size() != 0), 80'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("plaintext", 80'(plaintext), 80'(e.pt));
          check("cache_hit", 80'(cache_hit), 80'(e.hit));
          check("latency", 80'(cyc - e.start_cyc), 80'(e.hit ? LAT_HIT : LAT_MISS));
          check("busy_interval", 80'({busy_err, busy}), 80'(0));
        end
        busy_err = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 80'(0), 80'(1));
  endtask

  task automatic issue(input logic [79:0] k, input logic [63:0] ct, input logic [63:0] pt);
    wait_idle();
    mkey       = k;
    ciphertext = ct;
    exp_pt     = pt;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    logic [79:0] k, kb;
    logic [63:0] p, p2;
    int          d0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 80'({plaintext, busy, done, cache_hit}), 80'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Published PRESENT-80 vectors: miss, hit, key change miss, hit
    issue(80'h0, 64'h5579C1387B228445, 64'h0000000000000000);
    issue(80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF);
    issue({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0000000000000000);
    issue({80{1'b1}}, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF);
    wait_idle();

    // Start pulsed while busy, inputs changed mid-operation
    k  = rand_key();
    p  = {$urandom, $urandom};
    d0 = n_done;
    issue(k, present_enc(k, p), p);
    repeat (9) begin @(posedge clk); #1; end
    check("busy_midop", 80'(busy), 80'(1));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    mkey       = rand_key();
    ciphertext = {$urandom, $urandom};
    wait_idle();
    check("single_done", 80'(n_done - d0), 80'(1));

    // Reset at cycle 40 of a miss: immediate clear, no done, cache invalidated
    k = rand_key();
    p = {$urandom, $urandom};
    issue(k, present_enc(k, p), p);
    repeat (39) begin @(posedge clk); #1; end
    d0  = n_done;
    rst = 1'b0;
    #1;
    check("abort_outputs", 80'({plaintext, busy, done, cache_hit}), 80'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (70) begin @(posedge clk); #1; end
    check("abort_no_done", 80'(n_done - d0), 80'(0));
    issue(k, present_enc(k, p), p);
    wait_idle();

    // Back-to-back with start held high; second block hits the cache
    k  = rand_key();
    p  = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    wait_idle();
    d0         = n_done;
    mkey       = k;
    ciphertext = present_enc(k, p);
    exp_pt     = p;
    start      = 1'b1;
    @(posedge clk); #1;
    ciphertext = present_enc(k, p2);
    exp_pt     = p2;
    for (int n = 0; n < 200 && n_done == d0; n++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle();
    check("b2b_done_count", 80'(n_done - d0), 80'(2));
    check("b2b_spacing", 80'(last_done_cyc - prev_done_cyc), 80'(LAT_HIT + 1));

    // Random round trips, reusing keys often enough to exercise hits and misses
    kb = rand_key();
    for (int v = 0; v < 200; v++) begin
      if ($urandom_range(0, 2) != 0) kb = rand_key();
      p = {$urandom, $urandom};
      issue(kb, present_enc(kb, p), p);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/present_decrypt.md
Name: present_decrypt

Overview:
- Iterative PRESENT-80 decryption core, the inverse direction of the existing PRESENT encryption core.
- Takes an 80-bit master key and a 64-bit ciphertext, and returns the 64-bit plaintext.
- Executes one inverse round per clock.
- First derives the final round key K32 by running the forward key schedule.
- Optionally caches K32 so that back-to-back blocks under the same key skip expansion.

Parameters:
- KEY_CACHE, 1, 1 = keep {mkey, K32} from the last expansion and skip KEYEXP on a matching key; 0 = always expand.
- ROUNDS, 31, number of rounds. Must be 31 for standard PRESENT; smaller values are for reduced-round debug only.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- start  in  1  request a decryption; sampled only in IDLE.
- mkey  in  80  master key; sampled on the accepted start edge.
- ciphertext  in  64  input block; sampled on the accepted start edge.
- plaintext  out  64  result; valid from the done edge and held until the next done.
- busy  out  1  high from the accepted-start edge through the FIN edge.
- done  out  1  one-cycle pulse; plaintext is valid.
- cache_hit  out  1  registered with an accepted start; 1 when KEYEXP was skipped.

Behaviour:
- Reset values (rst=0, asynchronous):
  - plaintext=0, busy=0, done=0, cache_hit=0.
  - FSM=IDLE, round counter rc=0, cache_valid=0.
  - State and key registers cleared.
- States: IDLE, KEYEXP, DEC, FIN.
- IDLE:
  - done is forced to 0 one cycle after it pulses.
  - On start=1 (edge E0): state<=ciphertext, busy<=1.
  - Cache hit (KEY_CACHE=1, cache_valid=1, mkey==mkey_cache): key<=k32_cache, rc<=ROUNDS, cache_hit<=1, go to DEC.
  - Otherwise: key<=mkey, rc<=1, cache_hit<=0, go to KEYEXP.
- KEYEXP (forward schedule), per edge:
  - key <= fwd(key, rc), where fwd = rotate left 61, then S-box on bits[79:76], then bits[19:15] ^= rc.
  - rc++.
  - When rc==ROUNDS is applied, key holds K32. Then: k32_cache<=K32, mkey_cache<=mkey, cache_valid<=1 (only if KEY_CACHE=1), rc<=ROUNDS, go to DEC.
  - Exactly ROUNDS edges are spent in KEYEXP.
- DEC, per edge:
  - state <= invS(invP(state ^ key)).
  - key <= inv(key, rc), where inv = bits[19:15] ^= rc, then inverse S-box on bits[79:76], then rotate right 61.
  - rc--.
  - After the rc==1 edge, go to FIN; key now equals K1, which equals mkey.
  - Exactly ROUNDS edges are spent in DEC.
- FIN (one edge): plaintext<=state^key, done<=1, busy<=0, go to IDLE.
- Latency, counted from the accepted-start edge E0 to the done edge:
  - Miss: 2*ROUNDS+1 = 63 cycles.
  - Hit: ROUNDS+1 = 32 cycles.
- Arithmetic: rc is 5 bits and never wraps (range 1..31).
- Edge cases:
  - start while busy: ignored; inputs are not re-sampled.
  - start held high: a new operation is accepted on the first IDLE edge after FIN, so done and the new start's busy overlap back-to-back.
  - mkey or ciphertext changing mid-operation: no effect.
  - rst mid-operation: immediate abort; cache invalidated; no done pulse.
  - KEY_CACHE=0: cache_hit is constant 0 and cache registers are optimised away.

Decomposition:
- present_pkg holds:
  - SBOX and INV_SBOX (16x4 constants).
  - Functions for the p-layer and inverse p-layer, and for forward and inverse key updates.
  - State enum type.
  - Widths: KEY_W=80, BLK_W=64, RC_W=5.
- The encryption core reuses SBOX, the forward p-layer and the forward key update from present_pkg.
- Sub-module present_inv_round: combinational, (state, key) -> invS(invP(state^key)).

Test Plan:
- Reset, then mkey=0, ciphertext=64'h5579C1387B228445, start -> done after 63 cycles with plaintext=64'h0000000000000000, cache_hit=0; busy high for the whole interval.
- Same key again, ciphertext=64'hA112FFC72F68417B -> cache_hit=1, done after 32 cycles, plaintext=64'hFFFFFFFFFFFFFFFF.
- Key change:
  - mkey=80'hFFFF…FF, ciphertext=64'hE72C46C0F5945049 -> miss, 63 cycles, plaintext=0.
  - Then ciphertext=64'h3333DCD3213210D2 -> hit, plaintext=64'hFFFFFFFFFFFFFFFF.
- Pulse start again at cycle 10 of a busy operation, and change mkey/ciphertext at cycle 20 -> result unchanged, exactly one done.
- Assert rst=0 at cycle 40 of a miss -> outputs zero immediately, no done. After release, the same key produces cache_hit=0 and a correct result.
- Encrypt-then-decrypt round trip:
  - Drive random mkey and plaintext through the encryption core (PRESENT), then the ciphertext into present_decrypt; plaintext must match. Repeat for 200 vectors.
  - Check done and start back-to-back with start held high.
